// File: rtl/if_id_queue_pkg.sv
// Shared fetch/decode types for the if_id_queue slice.
// Entry layout and reset PC used by the front end.
package if_id_queue_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] RESET_PC = 32'h8000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } if_entry_t;

endpackage

// File: rtl/if_id_queue.sv
// In-order instruction queue from fetch to decode.
// Valid/ready on both sides, flush on PC redirect.
module if_id_queue
  import if_id_queue_pkg::*;
#(
  parameter int XLEN_P = XLEN,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [XLEN_P-1:0]          in_pc,
  input  logic [XLEN_P-1:0]          in_inst,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [XLEN_P-1:0]          out_pc,
  output logic [XLEN_P-1:0]          out_inst,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  logic          push;
  logic          pop;
  if_entry_t     mem [DEPTH];
  if_entry_t     head;

  assign in_ready  = (cnt != CW'(DEPTH));
  assign out_valid = (cnt != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign count     = cnt;

  assign head      = mem[rd_ptr];
  assign out_pc    = out_valid ? head.pc   : '0;
  assign out_inst  = out_valid ? head.inst : '0;

  // Pointers and occupancy; reset and flush both empty the queue.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Entry storage; not reset, contents are only visible when counted.
  always_ff @(posedge clk) begin
    if (!rst && !flush && push) begin
      mem[wr_ptr] <= '{pc: in_pc, inst: in_inst};
    end
  end

  a_cnt_bound: assert property (
    @(posedge clk) disable iff (rst) cnt <= CW'(DEPTH)
  );

endmodule

// File: tb/tb_if_id_queue.sv
// Directed bench for if_id_queue.
// Inputs change and outputs are sampled on the falling edge.
module tb_if_id_queue;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_inst;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic [2:0]  count;

  int n_chk;
  int n_pass;

  if_id_queue #(.DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pc     (in_pc),
    .in_inst   (in_inst),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pc    (out_pc),
    .out_inst  (out_inst),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    n_chk = 0;
    n_pass = 0;
    rst = 1'b1;
    flush = 1'b0;
    in_valid = 1'b0;
    in_pc = '0;
    in_inst = '0;
    out_ready = 1'b0;
    @(negedge clk);
    cyc();
    rst = 1'b0;
    cyc();

    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_pc", out_pc, 32'd0);
    chk("rst_inst", out_inst, 32'd0);

    in_valid = 1'b1;
    in_pc = 32'h8000_0000;
    in_inst = 32'h0000_0413;
    cyc();
    in_valid = 1'b0;
    chk("one_valid", 32'(out_valid), 32'd1);
    chk("one_pc", out_pc, 32'h8000_0000);
    chk("one_inst", out_inst, 32'h0000_0413);
    chk("one_count", 32'(count), 32'd1);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("hold_pc", out_pc, 32'h8000_0000);
      chk("hold_inst", out_inst, 32'h0000_0413);
    end
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    chk("one_drain", 32'(count), 32'd0);

    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_pc = 32'h8000_0000 + 32'(4 * i);
      in_inst = 32'h1000 + 32'(i);
      cyc();
    end
    chk("full_count", 32'(count), 32'd4);
    chk("full_ready", 32'(in_ready), 32'd0);
    in_pc = 32'h8000_0010;
    cyc();
    in_valid = 1'b0;
    chk("full_noacc", 32'(count), 32'd4);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_pc", out_pc, 32'h8000_0000 + 32'(4 * i));
      chk("drain_inst", out_inst, 32'h1000 + 32'(i));
      cyc();
    end
    chk("drain_empty", 32'(out_valid), 32'd0);

    for (int k = 0; k < 10; k++) begin
      in_valid = 1'b1;
      in_pc = 32'h8000_0400 + 32'(4 * k);
      in_inst = 32'h2000 + 32'(k);
      cyc();
      chk("strm_count", 32'(count), 32'd1);
      chk("strm_pc", out_pc, 32'h8000_0400 + 32'(4 * k));
    end
    in_valid = 1'b0;
    cyc();
    chk("strm_end", 32'(count), 32'd0);
    out_ready = 1'b0;

    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_pc = 32'h8000_0040 + 32'(4 * i);
      in_inst = 32'h3000 + 32'(i);
      cyc();
    end
    chk("pre_flush", 32'(count), 32'd3);
    flush = 1'b1;
    in_pc = 32'h8000_0100;
    in_inst = 32'hDEAD_BEEF;
    out_ready = 1'b1;
    cyc();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_valid", 32'(out_valid), 32'd0);
    for (int i = 0; i < 2; i++) begin
      cyc();
      chk("flush_gone", out_pc, 32'd0);
    end
    out_ready = 1'b0;

    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_pc = 32'h8000_0200 + 32'(4 * i);
      in_inst = 32'h4000 + 32'(i);
      cyc();
    end
    in_valid = 1'b0;
    chk("pre_rst", 32'(count), 32'd2);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("mid_rst_count", 32'(count), 32'd0);
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_pc", out_pc, 32'd0);
    in_valid = 1'b1;
    in_pc = 32'h8000_0300;
    in_inst = 32'h0000_ABCD;
    cyc();
    in_valid = 1'b0;
    chk("post_rst_pc", out_pc, 32'h8000_0300);
    chk("post_rst_inst", out_inst, 32'h0000_ABCD);
    chk("post_rst_count", 32'(count), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/if_id_queue.md
Name: if_id_queue

Overview:
- Instruction queue between the fetch stage and the decode stage.
- Accepts {pc, inst} pairs from fetch through a valid/ready handshake and buffers up to DEPTH entries in order.
- Presents the oldest entry to decode through a second valid/ready handshake.
- A synchronous flush discards all buffered instructions when the PC is redirected (branch, jump, trap).

Parameters:
- XLEN, 32: width of pc and inst.
- DEPTH, 4: number of entries. Power of two, DEPTH >= 2.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  discard all entries; sampled on the rising edge.
- in_valid  input  1  fetch offers an entry.
- in_ready  output  1  queue can accept an entry.
- in_pc  input  XLEN  PC of the offered instruction.
- in_inst  input  XLEN  instruction word fetched at in_pc.
- out_valid  output  1  head entry is available to decode.
- out_ready  input  1  decode consumes the head entry.
- out_pc  output  XLEN  PC of the head entry.
- out_inst  output  XLEN  instruction word of the head entry.
- count  output  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Reset: when rst is high at a rising edge:
  - wr_ptr, rd_ptr and count become 0; out_valid = 0; in_ready = 1.
  - out_pc and out_inst read 0 while the queue is empty.
  - Storage array is not reset.
- Handshakes:
  - push = in_valid & in_ready; pop = out_valid & out_ready.
  - in_ready = (count != DEPTH). It does not depend on out_ready: no push into a full queue, even while a pop occurs in the same cycle.
  - out_valid = (count != 0).
- Latency: no bypass. An entry pushed in cycle N is visible on out_* from cycle N+1.
- Storage read: out_pc/out_inst are read combinationally from storage[rd_ptr] and gated to 0 when empty. They stay stable while out_valid & !out_ready.
- Push: storage[wr_ptr] <= {in_pc, in_inst}; wr_ptr <= wr_ptr+1 modulo DEPTH (natural wrap, pointer width $clog2(DEPTH)).
- Pop: rd_ptr <= rd_ptr+1 modulo DEPTH.
- count update:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged, and both pointers advance. Legal when 0 < count < DEPTH.
- Pop when empty is impossible (out_valid = 0); out_ready is ignored.
- Flush: when flush is high at a rising edge:
  - Pointers and count become 0 and the stored entries are discarded.
  - A push or pop in the same cycle has no effect. The fetch entry offered in that cycle is dropped even though in_ready may be 1.
  - out_valid = 0 from the next cycle.
- Priority: rst > flush > push/pop.
- Reset mid-operation behaves exactly as a flush plus reset of outputs; no partial entry survives.
- Invariants: count <= DEPTH; count == (wr_ptr - rd_ptr) mod DEPTH, except that count == DEPTH when the pointers are equal and the queue is full.
- Simulation check: assertion fires if count ever exceeds DEPTH.

Decomposition:
- Shared package:
  - XLEN constant.
  - if_entry_t typedef {pc[XLEN-1:0], inst[XLEN-1:0]}.
  - Reset PC constant (reused by the PC register).
- Single module with no sub-module. Storage is a plain register array of if_entry_t.

Test Plan:
- Reset, then idle: out_valid=0, in_ready=1, count=0, out_pc=out_inst=0.
- Push pc=0x80000000 inst=0x00000413 with out_ready=0 → next cycle out_valid=1, out_pc=0x80000000, out_inst=0x00000413, count=1. Hold out_ready=0 for 3 cycles → outputs unchanged.
- Push 4 entries (pc 0x80000000..0x8000000C) with out_ready=0 → count=4, in_ready=0. A fifth in_valid is not accepted. Drain 4 pops → pcs appear in order, then out_valid=0.
- Steady stream with in_valid=out_ready=1 for 10 cycles → count stays 1 after the first cycle; pcs appear in order; pointers wrap past DEPTH without loss.
- Fill 3 entries, then assert flush together with in_valid (pc 0x80000100) and out_ready → next cycle count=0, out_valid=0; pc 0x80000100 never appears at out_*.
- Assert rst while count=2 → next cycle count=0, out_valid=0. A push after reset returns the new pc, not the stale ones.
